// File: rtl/sif_xa_arbiter_pkg.sv
// Shared definitions for the SIF XA arbiter slice.
//   E_ArbState  - arbiter FSM states
//   E_Operation - {rst_n, xa_wr_st, xa_rd_st} bus encoding, used by the
//                 protocol assertions and coverage points
//   sif_op()    - maps the three raw bits onto E_Operation
package sif_xa_arbiter_pkg;

  localparam int unsigned SIF_XA_TIMEOUT_DEFAULT = 15;
  localparam int unsigned SIF_XA_TIMER_W         = 8;

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_STROBE = 2'd1,
    A_WAIT   = 2'd2,
    A_RESP   = 2'd3
  } E_ArbState;

  typedef enum logic [2:0] {
    OP_RESET   = 3'b000,
    OP_IDLE    = 3'b100,
    OP_READ    = 3'b101,
    OP_WRITE   = 3'b110,
    OP_ILLEGAL = 3'b111
  } E_Operation;

  // Every combination with rst_n low collapses to OP_RESET so the result
  // is always a legal enum member.
  function automatic E_Operation sif_op(input logic rst_n,
                                        input logic wr_st,
                                        input logic rd_st);
    E_Operation op;
    if (!rst_n) begin
      op = OP_RESET;
    end else begin
      unique case ({wr_st, rd_st})
        2'b00:   op = OP_IDLE;
        2'b01:   op = OP_READ;
        2'b10:   op = OP_WRITE;
        default: op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/sif_xa_arbiter_rr_pick.sv
// sif_rr_pick - combinational round-robin picker.
//   req_i  : request vector
//   ptr_i  : index of the last served requester
//   gnt_o  : one-hot winner (zero when no request)
//   idx_o  : index of the winner
//   any_o  : at least one request present
// Scanning starts at ptr_i+1 and wraps, so the last served requester has
// the lowest priority.
module sif_rr_pick
  import sif_xa_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int             cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand     = (int'(ptr_i) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sif_xa_arbiter.sv
// sif_xa_arbiter - round-robin sequencer sharing one SIF XA port.
//   clk, rst_n        : clock, async active-low reset
//   req_vld_i/wr_i    : per-requester request and direction (1 = write)
//   req_addr_i/wdata_i: packed per-requester address / write data
//   req_gnt_o         : one-cycle one-hot grant pulse (coincides with strobe)
//   rsp_vld_o         : one-cycle one-hot completion pulse
//   rsp_rdata_o/err_o : read data / timeout flag, valid with rsp_vld_o
//   xa_wr_st_o/rd_st_o: SIF strobes, never both high
//   xa_addr_o/data_wr_o: SIF address / write data, held through WAIT
//   xa_data_rd_i/done_i: SIF read data and completion pulse
// All outputs come straight from flops.
module sif_xa_arbiter
  import sif_xa_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = SIF_XA_TIMEOUT_DEFAULT,
  localparam int IDX_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_vld_i,
  input  logic [N_REQ-1:0]    req_wr_i,
  input  logic [N_REQ*AW-1:0] req_addr_i,
  input  logic [N_REQ*DW-1:0] req_wdata_i,
  output logic [N_REQ-1:0]    req_gnt_o,
  output logic [N_REQ-1:0]    rsp_vld_o,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                xa_wr_st_o,
  output logic                xa_rd_st_o,
  output logic [AW-1:0]       xa_addr_o,
  output logic [DW-1:0]       xa_data_wr_o,
  input  logic [DW-1:0]       xa_data_rd_i,
  input  logic                xa_done_i
);

  localparam logic [SIF_XA_TIMER_W-1:0] TIMER_LAST = SIF_XA_TIMER_W'(TIMEOUT - 1);

  E_ArbState                 state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      wr_q, wr_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [DW-1:0]             wdata_q, wdata_d;
  logic [SIF_XA_TIMER_W-1:0] timer_q, timer_d;
  logic [N_REQ-1:0]          gnt_q, gnt_d;
  logic [N_REQ-1:0]          rsp_vld_q, rsp_vld_d;
  logic [DW-1:0]             rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      wr_st_q, wr_st_d;
  logic                      rd_st_q, rd_st_d;

  logic [N_REQ-1:0]          pick_gnt;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;

  sif_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req_vld_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    timer_d   = timer_q;
    gnt_d     = '0;
    rsp_vld_d = '0;
    rdata_d   = '0;
    err_d     = 1'b0;
    wr_st_d   = 1'b0;
    rd_st_d   = 1'b0;

    unique case (state_q)
      A_IDLE: begin
        // Outputs for STROBE are computed here so they are registered and
        // appear in the cycle right after the decision edge.
        if (pick_any) begin
          idx_d   = pick_idx;
          wr_d    = req_wr_i[pick_idx];
          addr_d  = req_addr_i[int'(pick_idx)*AW +: AW];
          wdata_d = req_wdata_i[int'(pick_idx)*DW +: DW];
          gnt_d   = pick_gnt;
          wr_st_d = req_wr_i[pick_idx];
          rd_st_d = !req_wr_i[pick_idx];
          state_d = A_STROBE;
        end
      end
      A_STROBE: begin
        // xa_done here is deliberately ignored.
        timer_d = '0;
        state_d = A_WAIT;
      end
      A_WAIT: begin
        if (xa_done_i) begin
          rsp_vld_d = N_REQ'(1) << idx_q;
          rdata_d   = wr_q ? '0 : xa_data_rd_i;
          state_d   = A_RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_vld_d = N_REQ'(1) << idx_q;
          err_d     = 1'b1;
          state_d   = A_RESP;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      A_RESP: begin
        ptr_d   = idx_q;
        state_d = A_IDLE;
      end
      default: state_d = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= A_IDLE;
      ptr_q     <= IDX_W'(N_REQ - 1);
      idx_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      timer_q   <= '0;
      gnt_q     <= '0;
      rsp_vld_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wr_st_q   <= 1'b0;
      rd_st_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
    end
  end

  assign req_gnt_o    = gnt_q;
  assign rsp_vld_o    = rsp_vld_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign xa_wr_st_o   = wr_st_q;
  assign xa_rd_st_o   = rd_st_q;
  assign xa_addr_o    = addr_q;
  assign xa_data_wr_o = wdata_q;

  E_Operation xa_op;
  assign xa_op = sif_op(rst_n, wr_st_q, rd_st_q);

  a_no_illegal_op: assert property (@(posedge clk) xa_op != OP_ILLEGAL);
  a_gnt_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
  a_rsp_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_vld_q));
  c_op_write:      cover property (@(posedge clk) xa_op == OP_WRITE);
  c_op_read:       cover property (@(posedge clk) xa_op == OP_READ);

endmodule

// File: tb/tb_sif_xa_arbiter.sv
module tb_sif_xa_arbiter;

  localparam int N_REQ = 4;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int TMO   = 15;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_vld = '0;
  logic [N_REQ-1:0]    req_wr = '0;
  logic [N_REQ*AW-1:0] req_addr = '0;
  logic [N_REQ*DW-1:0] req_wdata = '0;
  logic [N_REQ-1:0]    req_gnt;
  logic [N_REQ-1:0]    rsp_vld;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                xa_wr_st;
  logic                xa_rd_st;
  logic [AW-1:0]       xa_addr;
  logic [DW-1:0]       xa_data_wr;
  logic [DW-1:0]       xa_data_rd = '0;
  logic                xa_done = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  sif_xa_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld_i    (req_vld),
    .req_wr_i     (req_wr),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_gnt_o    (req_gnt),
    .rsp_vld_o    (rsp_vld),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .xa_wr_st_o   (xa_wr_st),
    .xa_rd_st_o   (xa_rd_st),
    .xa_addr_o    (xa_addr),
    .xa_data_wr_o (xa_data_wr),
    .xa_data_rd_i (xa_data_rd),
    .xa_done_i    (xa_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol monitor: strobe exclusivity, one-hot outputs, grant/response pairing.
  logic             busy = 1'b0;
  logic [N_REQ-1:0] busy_gnt = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      check_val("strobe_excl", 32'(xa_wr_st & xa_rd_st), 32'd0);
      if (req_gnt != '0) begin
        check_val("gnt_onehot", 32'($onehot(req_gnt)), 32'd1);
        check_val("gnt_while_busy", 32'(busy), 32'd0);
        busy     = 1'b1;
        busy_gnt = req_gnt;
      end
      if (rsp_vld != '0) begin
        check_val("rsp_has_gnt", 32'(busy), 32'd1);
        check_val("rsp_idx", 32'(rsp_vld), 32'(busy_gnt));
        busy = 1'b0;
      end
    end
  end

  // One transaction for a lone requester. dly: cycle after the strobe in
  // which xa_done is driven (0 = during the strobe itself, -1 = never).
  task automatic run_xact(input string nm, input int idx, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int dly, input logic [DW-1:0] rd_in);
    int exp_c;
    int got_c;
    logic exp_err;
    logic [DW-1:0] exp_rd;
    exp_err = (dly < 1);
    exp_c   = exp_err ? TMO + 1 : dly + 1;
    exp_rd  = (exp_err || wr) ? '0 : rd_in;
    req_vld[idx]              = 1'b1;
    req_wr[idx]               = wr;
    req_addr[idx*AW +: AW]    = addr;
    req_wdata[idx*DW +: DW]   = wdata;
    tick();
    check_val({nm, "_gnt"}, 32'(req_gnt), 32'(1 << idx));
    check_val({nm, "_wr_st"}, 32'(xa_wr_st), 32'(wr));
    check_val({nm, "_rd_st"}, 32'(xa_rd_st), 32'(!wr));
    check_val({nm, "_addr"}, 32'(xa_addr), 32'(addr));
    check_val({nm, "_wdata"}, 32'(xa_data_wr), 32'(wdata));
    req_vld[idx] = 1'b0;
    if (dly == 0) begin
      xa_done    = 1'b1;
      xa_data_rd = rd_in;
    end
    got_c = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      xa_done = 1'b0;
      if (c == 1) begin
        check_val({nm, "_strobe_off"}, 32'({xa_wr_st, xa_rd_st, |req_gnt}), 32'd0);
        check_val({nm, "_addr_hold"}, 32'(xa_addr), 32'(addr));
      end
      if (rsp_vld != '0) begin
        got_c = c;
        break;
      end
      if (c == dly) begin
        xa_done    = 1'b1;
        xa_data_rd = rd_in;
      end
    end
    check_val({nm, "_rsp_cycle"}, 32'(got_c), 32'(exp_c));
    check_val({nm, "_rsp_vld"}, 32'(rsp_vld), 32'(1 << idx));
    check_val({nm, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check_val({nm, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    tick();
    check_val({nm, "_rsp_pulse"}, 32'(rsp_vld), 32'd0);
  endtask

  task automatic wait_gnt(input string nm, input int budget, output int waited);
    waited = -1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      if (req_gnt != '0) begin
        waited = c;
        break;
      end
    end
    if (waited < 0) check_val({nm, "_timeout"}, 32'(req_gnt), 32'hFFFF_FFFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset values
    #1;
    check_val("rst_gnt", 32'(req_gnt), 32'd0);
    check_val("rst_rsp", 32'(rsp_vld), 32'd0);
    check_val("rst_strobes", 32'({xa_wr_st, xa_rd_st}), 32'd0);
    check_val("rst_addr_data", 32'({xa_addr, xa_data_wr}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Write with done two cycles after the strobe; read data must be ignored.
    xa_data_rd = 16'hAAAA;
    run_xact("wr0", 0, 1'b1, 8'h12, 16'hBEEF, 2, 16'hAAAA);
    tick();

    // Read with done in the first WAIT cycle.
    run_xact("rd2", 2, 1'b0, 8'h40, 16'h0000, 1, 16'h1234);
    tick();

    // Timeout, then a late completion that must not produce a response.
    xa_data_rd = 16'hDEAD;
    run_xact("tmo1", 1, 1'b0, 8'h55, 16'h0000, -1, 16'hDEAD);
    tick();
    xa_done = 1'b1;
    tick();
    xa_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_val("late_done_no_rsp", 32'(rsp_vld), 32'd0);
      tick();
    end

    // Done only during the strobe cycle: ignored, ends in timeout.
    run_xact("early3", 3, 1'b1, 8'h77, 16'h5A5A, 0, 16'h0000);
    tick();

    // Reset during WAIT, then requester 0 beats requester 3.
    req_vld[3] = 1'b1; req_wr[3] = 1'b0; req_addr[3*AW +: AW] = 8'h33;
    wait_gnt("pre_rst", 10, w);
    req_vld[3] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_val("midrst_gnt", 32'(req_gnt), 32'd0);
    check_val("midrst_rsp", 32'(rsp_vld), 32'd0);
    check_val("midrst_strobes", 32'({xa_wr_st, xa_rd_st, rsp_err}), 32'd0);
    check_val("midrst_addr_data", 32'({xa_addr, xa_data_wr}), 32'd0);
    req_vld = 4'b1001;
    req_addr[0 +: AW] = 8'h01;
    tick();
    xa_done = 1'b1;
    tick();
    xa_done = 1'b0;
    check_val("midrst_no_rsp", 32'(rsp_vld), 32'd0);
    rst_n = 1'b1;
    wait_gnt("post_rst", 10, w);
    check_val("post_rst_winner", 32'(req_gnt), 32'b0001);
    check_val("post_rst_addr", 32'(xa_addr), 32'h01);
    req_vld = '0;
    tick();
    xa_done = 1'b1;
    tick();
    xa_done = 1'b0;
    check_val("post_rst_rsp", 32'(rsp_vld), 32'b0001);
    tick();

    // Contention: all requesters held from reset.
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      req_addr[i*AW +: AW] = AW'(8'hA0 + i);
      req_wr[i] = i[0];
    end
    req_vld = '1;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      wait_gnt("cont", 10, w);
      check_val("cont_order", 32'(req_gnt), 32'(1 << (n % N_REQ)));
      check_val("cont_addr", 32'(xa_addr), 32'(8'hA0 + (n % N_REQ)));
      if (n > 0) check_val("cont_turnaround", 32'(w), 32'd2);
      tick();
      xa_done    = 1'b1;
      xa_data_rd = 16'(16'h1000 + n);
      tick();
      xa_done = 1'b0;
      check_val("cont_rsp", 32'(rsp_vld), 32'(1 << (n % N_REQ)));
      check_val("cont_rdata", 32'(rsp_rdata), (n % 2 == 1) ? 32'd0 : 32'(16'h1000 + n));
    end
    req_vld = '0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
